// File: rtl/conv_pkg.sv
// Shared convolver definitions: pixel format, kernel geometry and window packing.
// Used by the window buffer, multiplier and adder tree.
package conv_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int KERN_DIM    = 5;
    localparam int KERNEL_SIZE = KERN_DIM * KERN_DIM;

    typedef logic signed [DATA_WIDTH-1:0] pixel_t;

    // Flat element index of window row r (0 = oldest) and column c (0 = oldest).
    function automatic int win_idx(input int r, input int c);
        return r * KERN_DIM + c;
    endfunction

endpackage

// File: rtl/conv_window_buffer_if.sv
// Pixel stream in, packed convolution window out.
interface conv_window_buffer_if;
    import conv_pkg::*;

    pixel_t                              pixel_in;
    logic                                pixel_valid;
    logic [KERNEL_SIZE*DATA_WIDTH-1:0]   window_out;
    logic                                window_valid;
    logic                                frame_done;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  window_out,
        input  window_valid,
        input  frame_done
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output window_out,
        output window_valid,
        output frame_done
    );

endinterface

// File: rtl/conv_window_buffer_line_fifo.sv
// Single-row delay line: dout is the pixel shifted in DEPTH accepts ago.
// Storage is deliberately not reset; stale rows are masked by the window logic.
module line_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 28
) (
    input  logic   clk,
    input  logic   shift_en,
    input  pixel_t din,
    output pixel_t dout
);

    pixel_t mem_q [DEPTH];
    pixel_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/conv_window_buffer.sv
// Sliding KERN_DIM x KERN_DIM window generator over a raster pixel stream.
// Emits one window per accepted pixel once the window lies fully inside the image.
module conv_window_buffer
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                 clk,
    input  logic                 rstn,
    conv_window_buffer_if.slave  bus
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_FIRST = CW'(KERN_DIM - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERN_DIM - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          window_valid_q, window_valid_d;
    logic          frame_done_q, frame_done_d;
    pixel_t        win_q [KERN_DIM][KERN_DIM];
    pixel_t        win_d [KERN_DIM][KERN_DIM];

    logic          accept;
    pixel_t        fifo_in  [KERN_DIM-1];
    pixel_t        fifo_out [KERN_DIM-1];
    pixel_t        tap      [KERN_DIM];
    logic [KERNEL_SIZE*DATA_WIDTH-1:0] window_flat;

    assign accept = rstn & bus.pixel_valid;

    // fifo i delays by (i+1) rows, so its output is the oldest data in the cascade
    for (genvar i = 0; i < KERN_DIM - 1; i++) begin : g_fifo
        if (i == 0) begin : g_head
            assign fifo_in[i] = bus.pixel_in;
        end else begin : g_chain
            assign fifo_in[i] = fifo_out[i-1];
        end

        line_fifo #(
            .DEPTH (IMG_WIDTH)
        ) u_line_fifo (
            .clk      (clk),
            .shift_en (accept),
            .din      (fifo_in[i]),
            .dout     (fifo_out[i])
        );

        assign tap[i] = fifo_out[KERN_DIM-2-i];
    end
    assign tap[KERN_DIM-1] = bus.pixel_in;

    always_comb begin
        col_d          = col_q;
        row_d          = row_q;
        win_d          = win_q;
        window_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        if (bus.pixel_valid) begin
            window_valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            frame_done_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            for (int r = 0; r < KERN_DIM; r++) begin
                for (int c = 0; c < KERN_DIM - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KERN_DIM-1] = tap[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_q          <= '0;
            row_q          <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            for (int r = 0; r < KERN_DIM; r++) begin
                for (int c = 0; c < KERN_DIM; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            window_valid_q <= window_valid_d;
            frame_done_q   <= frame_done_d;
            win_q          <= win_d;
        end
    end

    always_comb begin
        window_flat = '0;
        for (int r = 0; r < KERN_DIM; r++) begin
            for (int c = 0; c < KERN_DIM; c++) begin
                window_flat[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

    assign bus.window_out   = window_flat;
    assign bus.window_valid = window_valid_q;
    assign bus.frame_done   = frame_done_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench: coordinate-based image model predicts every window.
module tb_conv_window_buffer;
    import conv_pkg::*;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int WB = KERNEL_SIZE * DATA_WIDTH;

    logic clk;
    logic rstn;

    conv_window_buffer_if bus ();

    conv_window_buffer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    logic [15:0]   img [H][W];
    int            m_row, m_col;
    logic [WB-1:0] exp_win;
    logic          exp_valid, exp_done, win_known;

    // per-frame observations
    int            f_nwin;
    logic [WB-1:0] f_first, f_fifth, f_done_win;
    logic [WB-1:0] win_log [$];
    logic [WB-1:0] cont_log [$];
    logic          prev_valid;
    int            consec;

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] elem(input logic [WB-1:0] w, input int idx);
        return w[idx*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    task automatic step(input logic rst_b, input logic v, input logic [15:0] d);
        rstn            = rst_b;
        bus.pixel_valid = v;
        bus.pixel_in    = d;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (!rst_b) begin
            m_row     = 0;
            m_col     = 0;
            exp_win   = '0;
            win_known = 1'b1;
        end else if (v) begin
            img[m_row][m_col] = d;
            if (m_row >= KERN_DIM - 1 && m_col >= KERN_DIM - 1) begin
                exp_valid = 1'b1;
                for (int r = 0; r < KERN_DIM; r++)
                    for (int c = 0; c < KERN_DIM; c++)
                        exp_win[(r*KERN_DIM+c)*DATA_WIDTH +: DATA_WIDTH] =
                            img[m_row-KERN_DIM+1+r][m_col-KERN_DIM+1+c];
                win_known = 1'b1;
            end else begin
                win_known = 1'b0;
            end
            exp_done = (m_row == H - 1) && (m_col == W - 1);
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end
        end
        @(posedge clk);
        #1;
        check("window_valid", WB'(bus.window_valid), WB'(exp_valid));
        check("frame_done", WB'(bus.frame_done), WB'(exp_done));
        if (win_known) check("window_out", bus.window_out, exp_win);
        if (bus.window_valid) begin
            f_nwin++;
            if (f_nwin == 1) f_first = bus.window_out;
            if (f_nwin == 5) f_fifth = bus.window_out;
            win_log.push_back(bus.window_out);
        end
        if (bus.frame_done) f_done_win = bus.window_out;
        if (prev_valid && bus.window_valid) consec++;
        prev_valid = bus.window_valid;
    endtask

    task automatic clear_frame();
        f_nwin     = 0;
        f_first    = '0;
        f_fifth    = '0;
        f_done_win = '0;
        win_log.delete();
    endtask

    // mode 0: continuous, 1: alternate valid/idle, 2: random gaps and data
    task automatic run_frame(input int offset, input int mode, input bit signed_px);
        logic [15:0] px;
        int gaps;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (mode == 2) begin
                    gaps = int'($urandom_range(0, 2));
                    for (int g = 0; g < gaps; g++) step(1'b1, 1'b0, 16'($urandom));
                    px = 16'($urandom);
                end else if (signed_px && r == 4 && c == 4) begin
                    px = 16'hFFFF;
                end else begin
                    px = 16'(r * W + c + offset);
                end
                step(1'b1, 1'b1, px);
                if (mode == 1) step(1'b1, 1'b0, 16'hA5A5);
            end
        end
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_count"}, WB'(win_log.size()), WB'(cont_log.size()));
        for (int i = 0; i < cont_log.size() && i < win_log.size(); i++)
            check(tag, win_log[i], cont_log[i]);
    endtask

    initial begin
        rstn            = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        prev_valid      = 1'b0;
        consec          = 0;
        m_row           = 0;
        m_col           = 0;
        exp_win         = '0;
        win_known       = 1'b1;
        clear_frame();

        // reset with pixel_valid high: input must be ignored
        step(1'b0, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 16'h4321);
        check("rst_window_out", bus.window_out, '0);

        // continuous frame
        clear_frame();
        run_frame(0, 0, 1'b0);
        check("cont_nwin", WB'(f_nwin), WB'(8));
        check("cont_first_e0", WB'(elem(f_first, 0)), WB'(0));
        check("cont_first_e24", WB'(elem(f_first, 24)), WB'(36));
        check("wrap_e0", WB'(elem(f_fifth, 0)), WB'(8));
        check("wrap_e24", WB'(elem(f_fifth, 24)), WB'(44));
        check("last_e0", WB'(elem(f_done_win, 0)), WB'(11));
        check("last_e24", WB'(elem(f_done_win, 24)), WB'(47));
        cont_log = win_log;

        // gapped frame
        step(1'b1, 1'b0, 16'h0);
        clear_frame();
        consec = 0;
        run_frame(0, 1, 1'b0);
        check("gap_nwin", WB'(f_nwin), WB'(8));
        check("gap_no_consec", WB'(consec), WB'(0));
        compare_logs("gap_seq");

        // mid-frame reset after 20 pixels
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'(i + 200));
        step(1'b0, 1'b1, 16'hDEAD);
        check("mrst_valid", WB'(bus.window_valid), '0);
        check("mrst_done", WB'(bus.frame_done), '0);
        check("mrst_window", bus.window_out, '0);
        clear_frame();
        run_frame(0, 0, 1'b0);
        check("mrst_nwin", WB'(f_nwin), WB'(8));
        compare_logs("mrst_seq");

        // back-to-back frames, no idle between
        clear_frame();
        run_frame(0, 0, 1'b0);
        clear_frame();
        run_frame(100, 0, 1'b0);
        check("b2b_nwin", WB'(f_nwin), WB'(8));
        check("b2b_first_e0", WB'(elem(f_first, 0)), WB'(100));
        check("b2b_first_e24", WB'(elem(f_first, 24)), WB'(136));

        // signed passthrough
        clear_frame();
        run_frame(0, 0, 1'b1);
        check("signed_e24", WB'(elem(f_first, 24)), WB'(16'hFFFF));
        check("signed_e0", WB'(elem(f_first, 0)), WB'(0));

        // randomized data and gaps
        for (int f = 0; f < 3; f++) begin
            clear_frame();
            run_frame(0, 2, 1'b0);
            check("rand_nwin", WB'(f_nwin), WB'(8));
        end
        step(1'b1, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_window_buffer.md
# conv_window_buffer

Streaming sliding-window generator feeding the convolver's multiplier / adder-tree datapath. It accepts one raster-order pixel per cycle and buffers KERN_DIM-1 image rows in line FIFOs. From these it assembles a KERN_DIM x KERN_DIM pixel window, packed in the layout the multiplier's `pixel_data` port consumes. It emits one window per accepted pixel once the window lies fully inside the image (valid convolution, no padding).

## Interface
- DATA_WIDTH, 16, pixel width (Q8.8 signed; block is value-agnostic)
- KERN_DIM, 5, kernel side length
- IMG_WIDTH, 28, pixels per row (must be >= KERN_DIM)
- IMG_HEIGHT, 28, rows per frame (must be >= KERN_DIM)
- clk  input  1  single clock; all logic on rising edge
- rstn  input  1  synchronous, active-low reset
- pixel_in  input  DATA_WIDTH  signed pixel, raster order
- pixel_valid  input  1  pixel_in accepted on this edge when high
- window_out  output  KERN_DIM*KERN_DIM*DATA_WIDTH  packed window; element (r,c) at bits [(r*KERN_DIM+c)*DATA_WIDTH +: DATA_WIDTH], r=0 oldest row, c=0 oldest column
- window_valid  output  1  one-cycle pulse, window_out holds a complete window
- frame_done  output  1  one-cycle pulse coincident with the frame's last window_valid

## Operation
- Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance only on accepted pixels. col wraps to 0 and increments row. After (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0 and the next pixel starts a new frame.
- KERN_DIM-1 cascaded line FIFOs, each IMG_WIDTH deep, shift on each accepted pixel. Taps give the same column from the previous KERN_DIM-1 rows.
- Window register: KERN_DIM rows x KERN_DIM columns. On accept, every row shifts one column toward c=0. Column c=KERN_DIM-1 loads {FIFO taps oldest..newest, pixel_in} into r=0..KERN_DIM-1.
- When the accepted pixel is at (row, col), the window holds pixels (row-KERN_DIM+1 .. row, col-KERN_DIM+1 .. col). Element index KERN_DIM*KERN_DIM-1 is the current pixel.
- window_valid is asserted iff the accepted pixel has row >= KERN_DIM-1 and col >= KERN_DIM-1. This gives (IMG_HEIGHT-KERN_DIM+1)*(IMG_WIDTH-KERN_DIM+1) windows per frame.
- Windows straddling a row wrap (col < KERN_DIM-1) are suppressed. Stale previous-frame data in the FIFOs is never exposed, because the first KERN_DIM-1 rows of each frame produce no window.
- No backpressure: downstream multiplier / adder tree is combinational and consumes every valid window.
- No arithmetic; pixel bits pass through unmodified (sign preserved).

## Timing
- Latency 1 cycle: pixel accepted at edge N; window_out and window_valid are registered and visible after edge N.
- pixel_valid low: counters, FIFOs and window_out hold; window_valid and frame_done deassert.
- Arbitrary gaps in pixel_valid are legal; back-to-back frames with no gap are legal.
- Reset (rstn low at an edge), including mid-frame:
  - col, row, window_valid, frame_done and window_out clear to 0.
  - FIFO storage is not cleared.
  - The first pixel accepted after reset is (0,0).
  - pixel_valid is ignored while rstn is low.
- Reset values: window_out = 0, window_valid = 0, frame_done = 0.

## Structure
- Shared package `conv_pkg`: DATA_WIDTH, KERN_DIM, KERNEL_SIZE = KERN_DIM*KERN_DIM, the window element index function (r*KERN_DIM+c), and a pixel typedef. The multiplier and adder tree use the same package.
- One sub-module `line_fifo`: single-row delay, depth IMG_WIDTH, shift-enable, no reset on storage. Instantiated KERN_DIM-1 times in a cascade.

## Test plan
Bench uses IMG_WIDTH=8, IMG_HEIGHT=6, KERN_DIM=5, with pixel value = row*8+col.
- **Continuous frame:** 48 pixels, pixel_valid held high.
  - First window_valid appears 1 cycle after pixel 36 (row 4, col 4), with element0=0 and element24=36.
  - Exactly 8 windows total.
  - frame_done occurs with the last window, where element0=11 and element24=47.
- **Gapped input:** pixel_valid alternates 1/0 over the same frame.
  - Window contents and sequence are identical to the continuous case.
  - window_valid is never high on two consecutive cycles.
- **Row wrap:** no window_valid for pixels (5,0)..(5,3). The window after (5,4) has element0=8 (pixel (1,0)) and element24=44.
- **Mid-frame reset:** drive rstn low for 1 cycle after 20 pixels.
  - All outputs read 0 the next cycle.
  - A fresh 48-pixel frame then reproduces the continuous-frame results exactly.
- **Back-to-back frames:** second frame values = row*8+col+100, with no idle cycle between frames.
  - The first window of frame 2 has element0=100.
  - No window_valid occurs during frame 2 rows 0-3.
- **Signed passthrough:** pixel (4,4) = 16'hFFFF. It appears unchanged at element24 of the first window.
